// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart bus arbiter: FSM state encoding,
// bus widths and the default response timeout.
package uart_arb_pkg;

  localparam int ADDR_W             = 32;
  localparam int WDATA_W            = 8;
  localparam int RDATA_W            = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Round-robin priority picker: first requester at or after ptr_i, scanning
// upward with wrap-around. Produces one-hot grant, binary index and any flag.
module uart_arb_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      int pos;
      pos = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing the uart register port between NUM_REQ masters
// with a 4-phase request/response handshake. UART_ARB_TIMEOUT_EN adds a response timeout.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ*WDATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [RDATA_W-1:0]         rdata_o,
  output logic [ADDR_W-1:0]          rw_address,
  output logic [WDATA_W-1:0]         write_data,
  output logic                       read_request,
  output logic                       write_request,
  input  logic [RDATA_W-1:0]         read_data,
  input  logic                       read_response,
  input  logic                       write_response
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WDATA_W-1:0]  wdata_q, wdata_d;
  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [RDATA_W-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  arb_req_t            sel;
  logic                rsp;

  uart_arb_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // One-hot AND-OR mux of the winning requester's command
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel.we    = sel.we | (gnt[k] & we_i[k]);
      sel.addr  = sel.addr | ({ADDR_W{gnt[k]}} & addr_i[k*ADDR_W +: ADDR_W]);
      sel.wdata = sel.wdata | ({WDATA_W{gnt[k]}} & wdata_i[k*WDATA_W +: WDATA_W]);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               timeout;
  // cnt_q counts completed ISSUE cycles; fire on the TIMEOUT_CYCLES-th one
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    rsp      = we_q ? write_response : read_response;
`ifdef UART_ARB_TIMEOUT_EN
    err_d    = '0;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          idx_d    = pick_idx;
          we_d     = sel.we;
          addr_d   = sel.addr;
          wdata_d  = sel.wdata;
          rd_req_d = ~sel.we;
          wr_req_d = sel.we;
          state_d  = ST_ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (rsp) begin
          rdata_d      = we_q ? '0 : read_data;
          ack_d[idx_q] = 1'b1;
          rd_req_d     = 1'b0;
          wr_req_d     = 1'b0;
          state_d      = ST_RELEASE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (timeout) begin
          rdata_d      = '0;
          ack_d[idx_q] = 1'b1;
          err_d[idx_q] = 1'b1;
          rd_req_d     = 1'b0;
          wr_req_d     = 1'b0;
          state_d      = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        // Both responses must fall before the next grant (4-phase handshake)
        if (!read_response && !write_response) begin
          rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  assign ack_o         = ack_q;
  assign rdata_o       = rdata_q;
  assign rw_address    = addr_q;
  assign write_data    = wdata_q;
  assign read_request  = rd_req_q;
  assign write_request = wr_req_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: behavioural uart responder plus a
// round-robin grant model; directed scenarios followed by randomized rounds.
module tb_uart_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;

  logic           clock, reset;
  logic [N-1:0]   req_i, we_i;
  logic [N*32-1:0] addr_i;
  logic [N*8-1:0] wdata_i;
  logic [N-1:0]   ack_o, err_o;
  logic [31:0]    rdata_o, rw_address, read_data;
  logic [7:0]     write_data;
  logic           read_request, write_request, read_response, write_response;

  logic           r_arr [N];
  logic           we_arr[N];
  logic [31:0]    a_arr [N];
  logic [7:0]     w_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign req_i[g]            = r_arr[g];
    assign we_i[g]             = we_arr[g];
    assign addr_i[g*32 +: 32]  = a_arr[g];
    assign wdata_i[g*8 +: 8]   = w_arr[g];
  end

  uart_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .rw_address(rw_address), .write_data(write_data), .read_request(read_request),
    .write_request(write_request), .read_data(read_data),
    .read_response(read_response), .write_response(write_response)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_ptr = 0;

  // Behavioural uart: responds after rsp_delay request cycles (0 = never),
  // keeps the response up rsp_hold cycles after the request drops.
  int          rsp_delay = 1, rsp_hold = 0, rsp_cnt = 0, rsp_left = 0;
  logic        rsp_act = 1'b0, rsp_fixed = 1'b0;
  logic [31:0] rsp_val = 32'h0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3C5A_96E1;
  endfunction

  initial begin
    read_response = 1'b0; write_response = 1'b0; read_data = 32'h0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        rsp_cnt = 0; rsp_act = 1'b0; read_response = 1'b0; write_response = 1'b0;
      end else if (rsp_act) begin
        if (!(read_request || write_request)) begin
          if (rsp_left == 0) begin
            read_response = 1'b0; write_response = 1'b0; rsp_act = 1'b0; rsp_cnt = 0;
          end else rsp_left--;
        end
      end else if (read_request || write_request) begin
        rsp_cnt++;
        if (rsp_delay != 0 && rsp_cnt >= rsp_delay) begin
          rsp_act = 1'b1; rsp_left = rsp_hold;
          read_data = read_request ? (rsp_fixed ? rsp_val : rd_fn(rw_address)) : 32'hDEAD_BEEF;
          read_response = read_request; write_response = write_request;
        end
      end else rsp_cnt = 0;
    end
  end

  // Reference round-robin rule: first set bit at or after p, with wrap-around
  function automatic int rr_pick_m(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (m[k]) return k;
    end
    return 0;
  endfunction

  typedef struct {
    logic        done;
    int          n_ack, n_rq, n_first;
    logic [N-1:0] ack, err;
    logic [31:0] rdata, addr;
    logic [7:0]  wd;
    logic        saw_rd, saw_wr;
  } obs_t;

  // Watches negedges until an ack (bounded); n counts from the next negedge
  task automatic observe(input int limit, output obs_t o);
    o.done = 1'b0; o.n_ack = -1; o.n_rq = 0; o.n_first = -1; o.ack = '0; o.err = '0;
    o.rdata = '0; o.addr = '0; o.wd = '0; o.saw_rd = 1'b0; o.saw_wr = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clock);
      if (read_request || write_request) begin
        if (o.n_first < 0) o.n_first = n;
        o.n_rq++;
        o.addr = rw_address; o.wd = write_data;
        o.saw_rd |= read_request; o.saw_wr |= write_request;
      end
      if (ack_o != '0) begin
        o.done = 1'b1; o.n_ack = n; o.ack = ack_o; o.err = err_o; o.rdata = rdata_o;
        break;
      end
    end
  endtask

  task automatic drive(input int k, input logic r, input logic we, input logic [31:0] a,
                       input logic [7:0] w);
    r_arr[k] = r; we_arr[k] = we; a_arr[k] = a; w_arr[k] = w;
  endtask

  task automatic go_idle(input int cyc);
    for (int i = 0; i < N; i++) r_arr[i] = 1'b0;
    repeat (cyc) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 32'h0, 8'h0);
    repeat (3) @(negedge clock);
    n_cmp++; if ({ack_o, err_o} !== '0) begin n_fail++; $display("FAIL rst_ack_err: got %b want 0", {ack_o, err_o}); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    n_cmp++; if (rw_address !== 32'h0 || write_data !== 8'h0) begin n_fail++; $display("FAIL rst_addr_data: got %h/%h want 0/0", rw_address, write_data); end
    n_cmp++; if ({read_request, write_request} !== 2'b00) begin n_fail++; $display("FAIL rst_req: got %b want 00", {read_request, write_request}); end
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if ({read_request, write_request, ack_o} !== '0) begin n_fail++; $display("FAIL idle_quiet: got %b want 0", {read_request, write_request, ack_o}); end
    exp_ptr = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_single_read;
    obs_t o;
    rsp_delay = 3; rsp_hold = 0; rsp_fixed = 1'b1; rsp_val = 32'h61;
    drive(0, 1'b1, 1'b0, 32'h1000_0004, 8'h00);
    observe(50, o);
    n_cmp++; if (!o.done) begin n_fail++; $display("FAIL sr_done: no ack within 50 cycles"); end
    n_cmp++; if (o.n_first !== 1 || o.n_rq !== 3) begin n_fail++; $display("FAIL sr_req_window: start %0d len %0d want 1/3", o.n_first, o.n_rq); end
    n_cmp++; if (o.n_ack !== 4) begin n_fail++; $display("FAIL sr_latency: ack at %0d want 4", o.n_ack); end
    n_cmp++; if (o.ack !== 2'b01 || o.err !== 2'b00) begin n_fail++; $display("FAIL sr_ack: got %b/%b want 01/00", o.ack, o.err); end
    n_cmp++; if (o.rdata !== 32'h61) begin n_fail++; $display("FAIL sr_rdata: got %h want 61", o.rdata); end
    n_cmp++; if (o.addr !== 32'h1000_0004 || o.saw_wr) begin n_fail++; $display("FAIL sr_bus: addr %h wr %b want 10000004/0", o.addr, o.saw_wr); end
    exp_ptr = 1;
    @(posedge clock); #1 r_arr[0] = 1'b0;
    @(negedge clock);
    n_cmp++; if (ack_o !== 2'b00 || rdata_o !== 32'h61) begin n_fail++; $display("FAIL sr_pulse_hold: ack %b rdata %h want 00/61", ack_o, rdata_o); end
    go_idle(3);
  endtask

  task automatic test_write;
    obs_t o;
    rsp_delay = 2; rsp_hold = 0; rsp_fixed = 1'b0;
    drive(1, 1'b1, 1'b1, 32'h1000_0000, 8'h41);
    observe(50, o);
    n_cmp++; if (!o.done || o.ack !== 2'b10) begin n_fail++; $display("FAIL wr_ack: done %b ack %b want 1/10", o.done, o.ack); end
    n_cmp++; if (!o.saw_wr || o.saw_rd) begin n_fail++; $display("FAIL wr_type: wr %b rd %b want 1/0", o.saw_wr, o.saw_rd); end
    n_cmp++; if (o.wd !== 8'h41 || o.addr !== 32'h1000_0000) begin n_fail++; $display("FAIL wr_bus: %h/%h want 41/10000000", o.wd, o.addr); end
    n_cmp++; if (o.rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", o.rdata); end
    exp_ptr = 0;
    go_idle(3);
  endtask

  task automatic test_back_to_back;
    obs_t o;
    int   w;
    rsp_delay = 2; rsp_hold = 0; rsp_fixed = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h1000_0014, 8'h0);
    drive(1, 1'b1, 1'b0, 32'h1000_0018, 8'h0);
    for (int t = 0; t < 4; t++) begin
      w = rr_pick_m(2'b11, exp_ptr);
      observe(50, o);
      n_cmp++; if (o.ack !== (N'(1) << w)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %b want %b", t, o.ack, N'(1) << w); end
      n_cmp++; if (o.rdata !== rd_fn(a_arr[w])) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", t, o.rdata, rd_fn(a_arr[w])); end
      n_cmp++; if (o.n_ack !== 3) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d want 4", t, o.n_ack + 1); end
      exp_ptr = (w + 1) % N;
      @(posedge clock); #1;
    end
    go_idle(3);
  endtask

  task automatic test_linger;
    obs_t o;
    rsp_delay = 1; rsp_hold = 5; rsp_fixed = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h1000_0008, 8'h0);
    observe(50, o);
    n_cmp++; if (o.ack !== 2'b01) begin n_fail++; $display("FAIL lg_first: ack %b want 01", o.ack); end
    rsp_hold = 0;
    @(posedge clock); #1;
    observe(50, o);
    n_cmp++; if (o.n_first !== 6) begin n_fail++; $display("FAIL lg_gap: reissue at %0d want 6", o.n_first); end
    n_cmp++; if (o.n_ack !== 7 || o.ack !== 2'b01) begin n_fail++; $display("FAIL lg_ack: at %0d ack %b want 7/01", o.n_ack, o.ack); end
    exp_ptr = 1;
    go_idle(3);
  endtask

  task automatic test_timeout;
    obs_t o;
    rsp_delay = 0; rsp_hold = 0;
    drive(0, 1'b1, 1'b0, 32'h1000_000C, 8'h0);
`ifdef UART_ARB_TIMEOUT_EN
    observe(60, o);
    n_cmp++; if (o.n_first !== 1 || o.n_rq !== TO) begin n_fail++; $display("FAIL to_window: start %0d len %0d want 1/%0d", o.n_first, o.n_rq, TO); end
    n_cmp++; if (o.n_ack !== TO + 1) begin n_fail++; $display("FAIL to_latency: ack at %0d want %0d", o.n_ack, TO + 1); end
    n_cmp++; if (o.ack !== 2'b01 || o.err !== 2'b01) begin n_fail++; $display("FAIL to_ack_err: %b/%b want 01/01", o.ack, o.err); end
    n_cmp++; if (o.rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", o.rdata); end
`else
    observe(40, o);
    n_cmp++; if (o.done || o.n_rq !== 39) begin n_fail++; $display("FAIL nto_wait: done %b len %0d want 0/39", o.done, o.n_rq); end
    rsp_delay = 1;
    observe(20, o);
    n_cmp++; if (o.ack !== 2'b01 || o.err !== 2'b00) begin n_fail++; $display("FAIL nto_ack: %b/%b want 01/00", o.ack, o.err); end
    n_cmp++; if (o.rdata !== rd_fn(32'h1000_000C)) begin n_fail++; $display("FAIL nto_rdata: got %h want %h", o.rdata, rd_fn(32'h1000_000C)); end
`endif
    exp_ptr = 1;
    go_idle(3);
  endtask

  task automatic test_reset_mid;
    obs_t o;
    rsp_delay = 0; rsp_hold = 0; rsp_fixed = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h1000_0020, 8'h0);
    drive(1, 1'b1, 1'b0, 32'h1000_0024, 8'h0);
    repeat (4) @(negedge clock);
    n_cmp++; if (!read_request || rw_address !== 32'h1000_0024) begin n_fail++; $display("FAIL rm_winner: req %b addr %h want 1/10000024", read_request, rw_address); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({read_request, write_request, ack_o, err_o} !== '0 || rw_address !== 32'h0) begin n_fail++; $display("FAIL rm_async_clear: req %b ack %b addr %h want 0", {read_request, write_request}, ack_o, rw_address); end
    @(negedge clock);
    n_cmp++; if (ack_o !== 2'b00) begin n_fail++; $display("FAIL rm_no_ack: got %b want 00", ack_o); end
    @(posedge clock); #1 reset = 1'b0;
    exp_ptr = 0; rsp_delay = 2;
    observe(50, o);
    n_cmp++; if (o.ack !== 2'b01 || o.addr !== 32'h1000_0020) begin n_fail++; $display("FAIL rm_rearb: ack %b addr %h want 01/10000020", o.ack, o.addr); end
    @(posedge clock); #1;
    observe(50, o);
    n_cmp++; if (o.ack !== 2'b10 || o.rdata !== rd_fn(32'h1000_0024)) begin n_fail++; $display("FAIL rm_second: ack %b rdata %h want 10/%h", o.ack, o.rdata, rd_fn(32'h1000_0024)); end
    exp_ptr = 0;
    go_idle(3);
  endtask

  task automatic test_random;
    obs_t        o;
    logic [N-1:0] pend;
    logic [31:0] erd;
    int          w;
    rsp_fixed = 1'b0;
    for (int r = 0; r < 40; r++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      rsp_delay = $urandom_range(1, 5);
      rsp_hold  = $urandom_range(0, 3);
      for (int k = 0; k < N; k++)
        drive(k, pend[k], 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
      while (pend != '0) begin
        w = rr_pick_m(pend, exp_ptr);
        erd = we_arr[w] ? 32'h0 : rd_fn(a_arr[w]);
        observe(200, o);
        n_cmp++; if (o.ack !== (N'(1) << w) || o.err !== '0) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b/%b want %b/0", r, o.ack, o.err, N'(1) << w); end
        n_cmp++; if (o.addr !== a_arr[w] || o.saw_wr !== we_arr[w] || o.saw_rd === we_arr[w]) begin n_fail++; $display("FAIL rnd_bus[%0d]: addr %h wr %b rd %b want %h we %b", r, o.addr, o.saw_wr, o.saw_rd, a_arr[w], we_arr[w]); end
        n_cmp++; if (we_arr[w] && o.wd !== w_arr[w]) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", r, o.wd, w_arr[w]); end
        n_cmp++; if (o.rdata !== erd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", r, o.rdata, erd); end
        n_cmp++; if (o.n_rq !== rsp_delay) begin n_fail++; $display("FAIL rnd_req_len[%0d]: got %0d want %0d", r, o.n_rq, rsp_delay); end
        exp_ptr = (w + 1) % N;
        pend[w] = 1'b0;
        @(posedge clock); #1 r_arr[w] = 1'b0;
      end
      go_idle(rsp_hold + 3);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_linger();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
